// File: rtl/clock_defs.sv
// clock_defs: shared mode encodings, field limits and 12-hour display mapping
package clock_defs;
  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2
  } mode_t;
  localparam logic [5:0] MAX_SEC  = 6'd59;
  localparam logic [5:0] MAX_MIN  = 6'd59;
  localparam logic [4:0] MAX_HOUR = 5'd23;
  function automatic logic [4:0] hour12(input logic [4:0] h);
    return h == 5'd0 ? 5'd12 : (h > 5'd12 ? h - 5'd12 : h);
  endfunction
endpackage

// File: rtl/btn_edge.sv
// btn_edge: two-flop synchronizer plus registered rising-edge pulse
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);
  logic [2:0] sh;
  // sh[1:0] synchronize, sh[2] holds the previous synchronized level
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh    <= '0;
      pulse <= 1'b0;
    end else begin
      sh    <= {sh[1:0], btn};
      pulse <= sh[1] & ~sh[2];
    end
endmodule

// File: rtl/time_keeper.sv
// time_keeper: time-of-day counter with set mode; optional TWELVE_HOUR_EN display mapping
module time_keeper
  import clock_defs::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int PRE_W  = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [6:0] sec,
  output logic [6:0] min,
  output logic [6:0] hour,
  output logic       pm,
  output logic [1:0] mode,
  output logic       blink
);
  logic             mode_p, inc_p, wrap, tick;
  logic [PRE_W-1:0] pre, pre_n;
  logic [5:0]       sec_r, sec_n, min_r, min_n;
  logic [4:0]       hr_r, hr_n;
  mode_t            st, st_n;
  btn_edge u_mode (.clk(clk), .rst_n(rst_n), .btn(btn_mode), .pulse(mode_p));
  btn_edge u_inc  (.clk(clk), .rst_n(rst_n), .btn(btn_inc),  .pulse(inc_p));
  // next-state: prescaler, carry chain in RUN, set-mode FSM and increments
  always_comb begin
    wrap  = pre == PRE_W'(CLK_HZ - 1);
    tick  = wrap && st == MODE_RUN;
    pre_n = wrap ? '0 : pre + 1'b1;
    sec_n = sec_r;
    min_n = min_r;
    hr_n  = hr_r;
    st_n  = st;
    if (tick) begin
      sec_n = sec_r == MAX_SEC ? 6'd0 : sec_r + 6'd1;
      if (sec_r == MAX_SEC) begin
        min_n = min_r == MAX_MIN ? 6'd0 : min_r + 6'd1;
        if (min_r == MAX_MIN) hr_n = hr_r == MAX_HOUR ? 5'd0 : hr_r + 5'd1;
      end
    end
    case (st)
      MODE_RUN:      if (mode_p) st_n = MODE_SET_HOUR;
      MODE_SET_HOUR: if (mode_p) st_n = MODE_SET_MIN;
                     else if (inc_p) hr_n = hr_r == MAX_HOUR ? 5'd0 : hr_r + 5'd1;
      MODE_SET_MIN:  if (mode_p) begin
                       st_n  = MODE_RUN;
                       sec_n = '0;
                       pre_n = '0;
                     end else if (inc_p) min_n = min_r == MAX_MIN ? 6'd0 : min_r + 6'd1;
      default:       st_n = MODE_RUN;
    endcase
  end
  // state and field registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pre   <= '0;
      sec_r <= '0;
      min_r <= '0;
      hr_r  <= '0;
      st    <= MODE_RUN;
    end else begin
      pre   <= pre_n;
      sec_r <= sec_n;
      min_r <= min_n;
      hr_r  <= hr_n;
      st    <= st_n;
    end
`ifdef TWELVE_HOUR_EN
  logic [4:0] hr12_r;
  logic       pm_r;
  // 12-hour view registered alongside the internal 24-hour field
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hr12_r <= 5'd12;
      pm_r   <= 1'b0;
    end else begin
      hr12_r <= hour12(hr_n);
      pm_r   <= hr_n >= 5'd12;
    end
  assign hour = {2'b00, hr12_r};
  assign pm   = pm_r;
`else
  assign hour = {2'b00, hr_r};
  assign pm   = 1'b0;
`endif
  assign sec   = {1'b0, sec_r};
  assign min   = {1'b0, min_r};
  assign mode  = st;
  assign blink = st != MODE_RUN && pre >= PRE_W'(CLK_HZ / 2);
endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: directed self-checking bench for time_keeper (CLK_HZ=10)
module tb_time_keeper;
  localparam int CLK_HZ = 10;
  localparam int PRE_W  = 4;
  logic       clk = 1'b0, rst_n = 1'b1, btn_mode = 1'b0, btn_inc = 1'b0;
  logic [6:0] sec, min, hour;
  logic       pm, blink;
  logic [1:0] mode;
  int         checks = 0, failures = 0, sec_at_set, bad;
  logic [19:0] bl;
  always #5 clk = ~clk;
  time_keeper #(.CLK_HZ(CLK_HZ), .PRE_W(PRE_W)) dut (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .sec(sec), .min(min), .hour(hour), .pm(pm), .mode(mode), .blink(blink)
  );
  function automatic int exp_hr(input int h);
`ifdef TWELVE_HOUR_EN
    return h == 0 ? 12 : (h > 12 ? h - 12 : h);
`else
    return h;
`endif
  endfunction
  function automatic int exp_pm(input int h);
`ifdef TWELVE_HOUR_EN
    return h >= 12 ? 1 : 0;
`else
    return 0;
`endif
  endfunction
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic chk_time(input string tag, input int h, input int m, input int s);
    chk({tag, "_hour"}, int'(hour), exp_hr(h));
    chk({tag, "_pm"}, int'(pm), exp_pm(h));
    chk({tag, "_min"}, int'(min), m);
    chk({tag, "_sec"}, int'(sec), s);
  endtask
  task automatic wait_mode(input int m, input string tag);
    for (int i = 0; i < 12 && int'(mode) != m; i++) step(1);
    chk(tag, int'(mode), m);
  endtask
  task automatic mode_to(input int m, input string tag);
    btn_mode = 1'b1;
    wait_mode(m, tag);
  endtask
  task automatic release_mode();
    btn_mode = 1'b0;
    step(4);
  endtask
  task automatic inc_n(input int n);
    for (int i = 0; i < n; i++) begin
      btn_inc = 1'b1;
      step(4);
      btn_inc = 1'b0;
      step(4);
    end
  endtask
  initial begin
    #1 rst_n = 1'b0;
    step(2);
    chk_time("rst", 0, 0, 0);
    chk("rst_mode", int'(mode), 0);
    chk("rst_blink", int'(blink), 0);
    rst_n = 1'b1;
    step(9);
    chk("sec_before_wrap", int'(sec), 0);
    step(1);
    chk("sec_first_tick", int'(sec), 1);
    step(90);
    chk_time("run100", 0, 0, 10);
    chk("run_mode", int'(mode), 0);
    chk("run_blink", int'(blink), 0);
    mode_to(1, "to_set_hour");
    sec_at_set = int'(sec);
    btn_mode = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bl[i] = blink;
      step(1);
    end
    bad = 0;
    for (int i = 0; i < 15; i++) if (bl[i+5] !== ~bl[i]) bad++;
    chk("blink_5_cycle_toggle", bad, 0);
    chk("set_sec_frozen", int'(sec), sec_at_set);
    inc_n(24);
    btn_inc = 1'b1;
    step(30);
    btn_inc = 1'b0;
    step(4);
    chk("hour_wrap", int'(hour), exp_hr(1));
    chk("hour_set_min", int'(min), 0);
    chk("hour_set_sec", int'(sec), sec_at_set);
    mode_to(2, "to_set_min");
    release_mode();
    inc_n(61);
    chk("min_wrap", int'(min), 1);
    chk("min_no_carry", int'(hour), exp_hr(1));
    mode_to(0, "to_run");
    chk("exit_sec_zero", int'(sec), 0);
    step(9);
    chk("exit_hold", int'(sec), 0);
    step(1);
    chk("exit_first_tick", int'(sec), 1);
    release_mode();
    mode_to(1, "to_set_hour2");
    release_mode();
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    wait_mode(2, "simul_mode");
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    step(4);
    chk("simul_hour", int'(hour), exp_hr(1));
    chk("simul_mode_hold", int'(mode), 2);
    #2 rst_n = 1'b0;
    #1;
    chk_time("async_rst", 0, 0, 0);
    chk("async_rst_mode", int'(mode), 0);
    chk("async_rst_blink", int'(blink), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
    mode_to(1, "roll_set_hour");
    release_mode();
    inc_n(23);
    mode_to(2, "roll_set_min");
    release_mode();
    inc_n(59);
    chk("roll_hour_set", int'(hour), exp_hr(23));
    chk("roll_min_set", int'(min), 59);
    mode_to(0, "roll_run");
    step(590);
    chk_time("pre_roll", 23, 59, 59);
    for (int i = 0; i < 9; i++) begin
      step(1);
      chk("hold_sec", int'(sec), 59);
      chk("hold_min", int'(min), 59);
      chk("hold_hour", int'(hour), exp_hr(23));
    end
    step(1);
    chk_time("rollover", 0, 0, 0);
    btn_mode = 1'b0;
    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
